// File: rtl/chest_mult_sched_if.sv
`default_nettype none
// ============================================================================
// Module     : chest_mult_sched_if
// Description: Bundle of the job, sample, multiplier and product signals that
//              the channel-estimation multiplier scheduler exchanges.
// Revision   : 1.0 - initial release
// ============================================================================
interface chest_mult_sched_if #(
    parameter int WIDTH_R_I = 16,
    parameter int N_RE      = 4
);
    logic                   start;
    logic [2*N_RE-1:0]      nrs_bits;
    logic                   s_valid;
    logic                   s_ready;
    logic [WIDTH_R_I-1:0]   s_rx_r;
    logic [WIDTH_R_I-1:0]   s_rx_i;
    logic                   mult_en;
    logic [1:0]             mult_wr_addr;
    logic [1:0]             mult_rd_addr;
    logic [WIDTH_R_I-1:0]   mult_rx_r;
    logic [WIDTH_R_I-1:0]   mult_rx_i;
    logic                   mult_nrs_r;
    logic                   mult_nrs_i;
    logic [WIDTH_R_I-1:0]   mult_real;
    logic [WIDTH_R_I-1:0]   mult_imag;
    logic                   m_valid;
    logic [1:0]             m_idx;
    logic [WIDTH_R_I-1:0]   m_real;
    logic [WIDTH_R_I-1:0]   m_imag;
    logic                   busy;
    logic                   done;

    // Environment side: job source, sample source, multiplier and estimator
    modport master (
        output start, nrs_bits, s_valid, s_rx_r, s_rx_i, mult_real, mult_imag,
        input  s_ready, mult_en, mult_wr_addr, mult_rd_addr, mult_rx_r,
               mult_rx_i, mult_nrs_r, mult_nrs_i, m_valid, m_idx, m_real,
               m_imag, busy, done
    );

    // Scheduler side
    modport slave (
        input  start, nrs_bits, s_valid, s_rx_r, s_rx_i, mult_real, mult_imag,
        output s_ready, mult_en, mult_wr_addr, mult_rd_addr, mult_rx_r,
               mult_rx_i, mult_nrs_r, mult_nrs_i, m_valid, m_idx, m_real,
               m_imag, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/chest_mult_sched.sv
`default_nettype none
// ============================================================================
// Module     : chest_mult_sched
// Description: Schedules N_RE received NRS resource elements of one job into a
//              fixed-latency (2 cycle) complex multiplier and tags the returning
//              products with their RE index.
// Revision   : 1.0 - initial release
// ============================================================================
module chest_mult_sched #(
    parameter int WIDTH_R_I = 16,
    parameter int N_RE      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    chest_mult_sched_if.slave    bus
);

    localparam int               CNT_W     = $clog2(N_RE + 1);
    localparam logic [CNT_W-1:0] C_N_RE    = CNT_W'(N_RE);
    localparam logic [CNT_W-1:0] C_LAST_RE = CNT_W'(N_RE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2*N_RE-1:0]     nrs_q, nrs_d;
    logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]      retire_cnt_q, retire_cnt_d;
    logic [1:0]            rd_addr_q, rd_addr_d;
    logic                  v1_q, v1_d;
    logic [1:0]            idx1_q, idx1_d;
    logic                  v2_q, v2_d;
    logic [1:0]            idx2_q, idx2_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  mult_en_q, mult_en_d;

    logic                  w_ready;
    logic                  w_issue;
    logic [1:0]            w_k;
    logic [WIDTH_R_I-1:0]  w_prod_r;
    logic [WIDTH_R_I-1:0]  w_prod_i;

    // Issue slot is the current issue count; it cannot wrap because s_ready
    // drops once all N_RE samples have been taken.
    assign w_ready  = (state_q == RUN) && (issue_cnt_q < C_N_RE);
    assign w_issue  = bus.s_valid && w_ready;
    assign w_k      = issue_cnt_q[1:0];
    assign w_prod_r = bus.mult_real;
    assign w_prod_i = bus.mult_imag;

    assign bus.s_ready      = w_ready;
    assign bus.mult_wr_addr = w_ready ? w_k : 2'd0;
    assign bus.mult_rx_r    = bus.s_rx_r;
    assign bus.mult_rx_i    = bus.s_rx_i;
    assign bus.mult_nrs_r   = nrs_q[{w_k, 1'b1}];
    assign bus.mult_nrs_i   = nrs_q[{w_k, 1'b0}];
    assign bus.mult_rd_addr = rd_addr_q;
    assign bus.m_valid      = v2_q;
    assign bus.m_idx        = idx2_q;
    assign bus.m_real       = w_prod_r;
    assign bus.m_imag       = w_prod_i;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.mult_en      = mult_en_q;

    // Next-state: job FSM, counters, two-stage index tag pipeline, outputs
    always_comb begin
        state_d      = state_q;
        nrs_d        = nrs_q;
        issue_cnt_d  = issue_cnt_q;
        retire_cnt_d = retire_cnt_q;
        rd_addr_d    = rd_addr_q;
        v1_d         = w_issue;
        idx1_d       = w_k;
        v2_d         = v1_q;
        idx2_d       = idx1_q;

        if (w_issue) begin
            rd_addr_d   = w_k;
            issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (v2_q) begin
            retire_cnt_d = retire_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = RUN;
                    nrs_d        = bus.nrs_bits;
                    issue_cnt_d  = '0;
                    retire_cnt_d = '0;
                end
            end
            RUN: begin
                if (w_issue && (issue_cnt_q == C_LAST_RE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as the last product retires so DONE follows it directly
                if (v2_q && (retire_cnt_q == C_LAST_RE)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d    = (state_d == RUN) || (state_d == DRAIN);
        mult_en_d = busy_d;
        done_d    = (state_d == DONE);
    end

    // State register with synchronous reset that also aborts in-flight tags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            nrs_q        <= '0;
            issue_cnt_q  <= '0;
            retire_cnt_q <= '0;
            rd_addr_q    <= 2'd0;
            v1_q         <= 1'b0;
            idx1_q       <= 2'd0;
            v2_q         <= 1'b0;
            idx2_q       <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mult_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            nrs_q        <= nrs_d;
            issue_cnt_q  <= issue_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            rd_addr_q    <= rd_addr_d;
            v1_q         <= v1_d;
            idx1_q       <= idx1_d;
            v2_q         <= v2_d;
            idx2_q       <= idx2_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mult_en_q    <= mult_en_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/chest_mult_sched.md
CHEST_MULT_SCHED -- requirements
Module: chest_mult_sched

Interface
REQ-001 Parameters SHALL be:
- WIDTH_R_I, 16, bit width of each real/imag sample and product component.
- N_RE, 4, NRS resource elements per job; fixed at 4 to match the 2-bit multiplier slot address.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request pulse.
- nrs_bits  in  2*N_RE  NRS sign pair per RE; bit 2k+1 = nrs_r(k), bit 2k = nrs_i(k).
- s_valid  in  1  input RE sample valid.
- s_ready  out  1  scheduler accepts sample.
- s_rx_r, s_rx_i  in  WIDTH_R_I each  received RE real/imag.
- mult_en  out  1  multiplier enable.
- mult_wr_addr, mult_rd_addr  out  2 each  multiplier write/read slot.
- mult_rx_r, mult_rx_i  out  WIDTH_R_I each  sample to multiplier.
- mult_nrs_r, mult_nrs_i  out  1 each  NRS sign bits to multiplier.
- mult_real, mult_imag  in  WIDTH_R_I each  multiplier products.
- m_valid  out  1  product valid.
- m_idx  out  2  RE index of product.
- m_real, m_imag  out  WIDTH_R_I each  product to estimator.
- busy  out  1  job in progress.
- done  out  1  one-cycle job completion pulse.
REQ-003 Clock/reset SHALL be one clock, reset synchronous active-high, ports named clk and rst.

Function
REQ-004 FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-005 IDLE->RUN on start=1; nrs_bits SHALL be latched in the same edge; issue/retire counters cleared.
REQ-006 start SHALL be ignored when not in IDLE (no relatch, no error).
REQ-007 s_ready SHALL be 1 only in RUN with issue_cnt<N_RE; a sample SHALL issue on s_valid&&s_ready.
REQ-008 On issue of RE k (cycle t): mult_wr_addr=k, mult_rx_r/i=s_rx_r/i, mult_nrs_r=nrs_bits[2k+1], mult_nrs_i=nrs_bits[2k], all combinational in cycle t.
REQ-009 mult_rd_addr SHALL equal k in cycle t+1; held at last value otherwise.
REQ-010 m_valid=1, m_idx=k SHALL be asserted in cycle t+2 (fixed latency 2); m_real/m_imag SHALL be mult_real/mult_imag unmodified.
REQ-011 Issues MAY be back-to-back (one per cycle) or gapped by s_valid=0; tag pipeline SHALL preserve order and index for every pattern.
REQ-012 RUN->DRAIN on issue of RE N_RE-1; DRAIN->DONE when retire_cnt reaches N_RE; DONE->IDLE unconditionally after one cycle.
REQ-013 done SHALL be 1 only in DONE; busy SHALL be 1 in RUN and DRAIN.
REQ-014 mult_en SHALL be 1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-015 Exactly N_RE m_valid pulses SHALL occur per job, indices 0..N_RE-1 ascending.
REQ-016 m_idx, mult addresses SHALL never exceed N_RE-1; issue counter SHALL not wrap.

Reset
REQ-017 rst=1 SHALL force IDLE; s_ready, mult_en, m_valid, busy, done=0; mult_wr_addr, mult_rd_addr, m_idx=0; counters and tag pipeline cleared.
REQ-018 rst mid-job SHALL abort: no m_valid or done after the reset edge; next start SHALL run a clean job.
REQ-019 rst SHALL override start in the same cycle.

Verification
REQ-020 Back-to-back: start, nrs_bits=8'b10_01_11_00, s_valid held 1 with rx_r/i=k+1 -> wr_addr 0,1,2,3 on cycles 1-4; nrs pairs (0,0),(1,1),(0,1),(1,0); m_valid cycles 3-6 idx 0-3; done cycle 7.
REQ-021 Gapped input: s_valid 1,0,0,1,1,0,1 -> m_valid exactly 2 cycles after each accepted sample, idx ascending, done one cycle after idx 3.
REQ-022 start asserted during RUN with different nrs_bits -> ignored; original nrs pairs used; single done.
REQ-023 rst pulse after 2 issues -> all outputs reset values next cycle; no further m_valid; following job completes with 4 products.
REQ-024 start and rst in same cycle -> stays IDLE, busy=0.
REQ-025 Product pass-through: mult_real=16'h7FFF, mult_imag=16'h8000 in a valid cycle -> m_real=16'h7FFF, m_imag=16'h8000.
